// File: rtl/aip_slave_interface.sv
// -----------------------------------------------------------------------------
// aip_slave_interface
//
// Device-side responder for the AIP host bus. Host transactions are decoded
// into auto-incrementing accesses to memories X/Y/Z, pointer loads, a 10-bit
// configuration register (csize), the STATUS/interrupt register and a
// read-only IP ID. The convolution core reads X/Y and writes Z through its own
// ports, receives a one-cycle start pulse and returns a one-cycle done pulse.
//
// Ports
//   clk, rst_a              : clock, asynchronous active-high reset
//   en_s                    : synchronous enable; 0 freezes all state
//   data_in / data_out      : host write data / registered host read data
//   write, read, start      : host strobes
//   conf_dbus               : host target select
//   int_req                 : interrupt request, active-low, registered
//   x_addr/x_data, y_addr/y_data : core read ports (combinational data)
//   z_we, z_addr, z_data    : core write port for Z
//   csize                   : configuration register
//   core_start, core_done   : start pulse to / done pulse from the core
// -----------------------------------------------------------------------------
module aip_slave_interface #(
    parameter int                   DATAWIDTH   = 32,
    parameter int                   SIZE_MEMX   = 10,
    parameter int                   SIZE_MEMY   = 5,
    parameter int                   SIZE_MEMZ   = 15,
    parameter logic [DATAWIDTH-1:0] IP_ID_VALUE = 32'h1000500A
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         en_s,
    input  logic [DATAWIDTH-1:0]         data_in,
    output logic [DATAWIDTH-1:0]         data_out,
    input  logic                         write,
    input  logic                         read,
    input  logic                         start,
    input  logic [4:0]                   conf_dbus,
    output logic                         int_req,
    input  logic [$clog2(SIZE_MEMX)-1:0] x_addr,
    output logic [DATAWIDTH-1:0]         x_data,
    input  logic [$clog2(SIZE_MEMY)-1:0] y_addr,
    output logic [DATAWIDTH-1:0]         y_data,
    input  logic                         z_we,
    input  logic [$clog2(SIZE_MEMZ)-1:0] z_addr,
    input  logic [DATAWIDTH-1:0]         z_data,
    output logic [9:0]                   csize,
    output logic                         core_start,
    input  logic                         core_done
);

    localparam int XAW = $clog2(SIZE_MEMX);
    localparam int YAW = $clog2(SIZE_MEMY);
    localparam int ZAW = $clog2(SIZE_MEMZ);

    localparam logic [XAW-1:0] X_LAST = XAW'(SIZE_MEMX - 1);
    localparam logic [YAW-1:0] Y_LAST = YAW'(SIZE_MEMY - 1);
    localparam logic [ZAW-1:0] Z_LAST = ZAW'(SIZE_MEMZ - 1);

    // Target select codes on conf_dbus
    localparam logic [4:0] C_MX     = 5'd0;
    localparam logic [4:0] C_AX     = 5'd1;
    localparam logic [4:0] C_MY     = 5'd2;
    localparam logic [4:0] C_AY     = 5'd3;
    localparam logic [4:0] C_MZ     = 5'd4;
    localparam logic [4:0] C_AZ     = 5'd5;
    localparam logic [4:0] C_CSIZE  = 5'd6;
    localparam logic [4:0] C_ASIZE  = 5'd7;
    localparam logic [4:0] C_STATUS = 5'd30;
    localparam logic [4:0] C_IPID   = 5'd31;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    logic [DATAWIDTH-1:0] mem_x [SIZE_MEMX];
    logic [DATAWIDTH-1:0] mem_y [SIZE_MEMY];
    logic [DATAWIDTH-1:0] mem_z [SIZE_MEMZ];

    state_e               state_q;
    logic                 core_start_q;
    logic [XAW-1:0]       ptr_x_q, ptr_x_d, ptr_x_inc;
    logic [YAW-1:0]       ptr_y_q, ptr_y_d, ptr_y_inc;
    logic [ZAW-1:0]       ptr_z_q, ptr_z_d, ptr_z_inc;
    logic [9:0]           csize_q, csize_d;
    logic [7:0]           mask_q, mask_d;
    logic [7:0]           flags_q, flags_d;
    logic [DATAWIDTH-1:0] data_out_q, data_out_d;
    logic                 int_req_q;
    logic [DATAWIDTH-1:0] status_word, csize_word;
    logic                 host_wr, host_rd;

    // A write in the same cycle as a read wins; the read is dropped entirely.
    assign host_wr = en_s & write;
    assign host_rd = en_s & read & ~write;

    assign ptr_x_inc = (ptr_x_q == X_LAST) ? '0 : ptr_x_q + 1'b1;
    assign ptr_y_inc = (ptr_y_q == Y_LAST) ? '0 : ptr_y_q + 1'b1;
    assign ptr_z_inc = (ptr_z_q == Z_LAST) ? '0 : ptr_z_q + 1'b1;

    always_comb begin
        status_word        = '0;
        status_word[7:0]   = flags_q;
        status_word[8]     = (state_q == S_BUSY);
        status_word[23:16] = mask_q;
        csize_word         = '0;
        csize_word[9:0]    = csize_q;
    end

    // Next-state for the host-visible registers.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        ptr_x_d    = ptr_x_q;
        ptr_y_d    = ptr_y_q;
        ptr_z_d    = ptr_z_q;
        csize_d    = csize_q;
        mask_d     = mask_q;
        flags_d    = flags_q;
        data_out_d = data_out_q;

        if (host_wr) begin
            unique case (conf_dbus)
                C_MX:     ptr_x_d = ptr_x_inc;
                C_MY:     ptr_y_d = ptr_y_inc;
                // Out-of-range pointer values collapse to 0.
                C_AX:     ptr_x_d = (data_in < DATAWIDTH'(SIZE_MEMX)) ? data_in[XAW-1:0] : '0;
                C_AY:     ptr_y_d = (data_in < DATAWIDTH'(SIZE_MEMY)) ? data_in[YAW-1:0] : '0;
                C_AZ:     ptr_z_d = (data_in < DATAWIDTH'(SIZE_MEMZ)) ? data_in[ZAW-1:0] : '0;
                C_CSIZE:  csize_d = data_in[9:0];
                // csize is a single register, so its pointer is always 0.
                C_ASIZE:  ;
                C_STATUS: begin
                    mask_d  = data_in[23:16];
                    flags_d = flags_q & ~data_in[7:0];
                end
                default:  ;
            endcase
        end

        if (host_rd) begin
            unique case (conf_dbus)
                C_MX: begin
                    data_out_d = mem_x[ptr_x_q];
                    ptr_x_d    = ptr_x_inc;
                end
                C_MY: begin
                    data_out_d = mem_y[ptr_y_q];
                    ptr_y_d    = ptr_y_inc;
                end
                C_MZ: begin
                    data_out_d = mem_z[ptr_z_q];
                    ptr_z_d    = ptr_z_inc;
                end
                C_CSIZE:  data_out_d = csize_word;
                C_STATUS: data_out_d = status_word;
                C_IPID:   data_out_d = IP_ID_VALUE;
                default:  data_out_d = '0;
            endcase
        end

        // Applied after the W1C so a simultaneous done keeps the flag set.
        if (en_s && core_done && state_q == S_BUSY) begin
            flags_d[0] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            ptr_x_q    <= '0;
            ptr_y_q    <= '0;
            ptr_z_q    <= '0;
            csize_q    <= '0;
            mask_q     <= '0;
            flags_q    <= '0;
            data_out_q <= '0;
            int_req_q  <= 1'b1;
        end else begin
            ptr_x_q    <= ptr_x_d;
            ptr_y_q    <= ptr_y_d;
            ptr_z_q    <= ptr_z_d;
            csize_q    <= csize_d;
            mask_q     <= mask_d;
            flags_q    <= flags_d;
            data_out_q <= data_out_d;
            int_req_q  <= ~|(flags_q & mask_q);
        end
    end

    // Control FSM with registered start pulse.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q      <= S_IDLE;
            core_start_q <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            if (en_s) begin
                unique case (state_q)
                    S_IDLE: if (start) begin
                        core_start_q <= 1'b1;
                        state_q      <= S_BUSY;
                    end
                    S_BUSY: if (core_done) begin
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: memory arrays have no reset; contents are undefined until written,
    // which keeps them mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (host_wr && conf_dbus == C_MX) mem_x[ptr_x_q] <= data_in;
        if (host_wr && conf_dbus == C_MY) mem_y[ptr_y_q] <= data_in;
        if (en_s && z_we && z_addr <= Z_LAST) mem_z[z_addr] <= z_data;
    end

    assign x_data     = (x_addr <= X_LAST) ? mem_x[x_addr] : '0;
    assign y_data     = (y_addr <= Y_LAST) ? mem_y[y_addr] : '0;
    assign data_out   = data_out_q;
    assign int_req    = int_req_q;
    assign csize      = csize_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_aip_slave_interface.sv
// -----------------------------------------------------------------------------
// Self-checking bench for aip_slave_interface: a vector table for the
// host register/memory traffic plus directed sequences for start/done,
// interrupt timing, Z collisions, reset mid-burst and the enable gate.
// -----------------------------------------------------------------------------
module tb_aip_slave_interface;

    localparam logic [4:0] C_MX = 5'd0, C_AX = 5'd1, C_MY = 5'd2, C_AY = 5'd3;
    localparam logic [4:0] C_MZ = 5'd4, C_AZ = 5'd5, C_CS = 5'd6;
    localparam logic [4:0] C_ST = 5'd30, C_ID = 5'd31;
    localparam logic [31:0] ID = 32'h1000500A;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        en_s = 1'b1;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        write = 1'b0, read = 1'b0, start = 1'b0;
    logic [4:0]  conf_dbus = '0;
    logic        int_req;
    logic [3:0]  x_addr = '0;
    logic [31:0] x_data;
    logic [2:0]  y_addr = '0;
    logic [31:0] y_data;
    logic        z_we = 1'b0;
    logic [3:0]  z_addr = '0;
    logic [31:0] z_data = '0;
    logic [9:0]  csize;
    logic        core_start;
    logic        core_done = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aip_slave_interface dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .en_s       (en_s),
        .data_in    (data_in),
        .data_out   (data_out),
        .write      (write),
        .read       (read),
        .start      (start),
        .conf_dbus  (conf_dbus),
        .int_req    (int_req),
        .x_addr     (x_addr),
        .x_data     (x_data),
        .y_addr     (y_addr),
        .y_data     (y_data),
        .z_we       (z_we),
        .z_addr     (z_addr),
        .z_data     (z_data),
        .csize      (csize),
        .core_start (core_start),
        .core_done  (core_done)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [4:0]  code;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [4:0] code,
                       input logic [31:0] din, input logic [31:0] exp_dout);
        vec_t v;
        v.w = w; v.r = r; v.code = code; v.din = din; v.exp_dout = exp_dout;
        vecs.push_back(v);
    endtask

    // One bus cycle: drive at a falling edge, return at the next falling edge.
    task automatic cyc(input logic w, input logic r, input logic st,
                       input logic [4:0] code, input logic [31:0] d);
        write = w; read = r; start = st; conf_dbus = code; data_in = d;
        @(negedge clk);
        write = 1'b0; read = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [31:0] xexp [10];
        logic [31:0] burst [10];
        burst = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h3, 32'h7, 32'h6, 32'hA, 32'h5, 32'h8};

        // Vector table: {write, read, code, data_in, expected data_out}
        add(0, 1, C_ID, 0, ID);
        add(0, 1, C_ST, 0, 0);
        add(1, 0, C_AX, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 0, C_MX, burst[i], 0);
        add(1, 0, C_AX, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, C_MX, 0, burst[i]);
        add(0, 1, C_MX, 0, 32'h1);          // wrap 9 -> 0
        add(1, 0, C_AX, 12, 32'h1);         // out of range loads 0
        add(0, 1, C_MX, 0, 32'h1);
        add(1, 0, C_AX, 9, 32'h1);
        add(0, 1, C_MX, 0, 32'h8);
        add(0, 1, C_MX, 0, 32'h1);          // wrap after last word
        add(1, 0, C_AY, 4, 32'h1);
        add(1, 0, C_MY, 32'h55, 32'h1);
        add(1, 0, C_MY, 32'h66, 32'h1);     // lands in Y[0] after wrap
        add(1, 0, C_AY, 4, 32'h1);
        add(0, 1, C_MY, 0, 32'h55);
        add(0, 1, C_MY, 0, 32'h66);
        add(1, 0, C_AY, 5, 32'h66);         // == size loads 0
        add(0, 1, C_MY, 0, 32'h66);
        add(0, 1, C_ID, 0, ID);
        add(0, 1, 5'd9, 0, 0);              // undefined code
        add(0, 1, C_ID, 0, ID);
        add(0, 1, C_CS, 0, 0);
        add(1, 0, C_AX, 0, 0);
        add(1, 1, C_MX, 32'hDEAD, 0);       // write wins, read dropped
        add(0, 1, C_MX, 0, 32'h2);
        add(1, 0, C_AX, 0, 32'h2);
        add(0, 1, C_MX, 0, 32'hDEAD);

        // Reset
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        check("rst_dout", data_out, 0);
        check("rst_int_req", {31'd0, int_req}, 1);
        check("rst_core_start", {31'd0, core_start}, 0);
        check("rst_csize", {22'd0, csize}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].w, vecs[i].r, 1'b0, vecs[i].code, vecs[i].din);
            check($sformatf("vec%0d", i), data_out, vecs[i].exp_dout);
        end

        // Core-side view of X and Y
        xexp = burst;
        xexp[0] = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            x_addr = 4'(i);
            #1 check($sformatf("x_data%0d", i), x_data, xexp[i]);
        end
        y_addr = 3'd4;
        #1 check("y_data4", y_data, 32'h55);
        y_addr = 3'd0;
        #1 check("y_data0", y_data, 32'h66);

        // Mask, csize, start pulse
        cyc(1, 0, 0, C_ST, 32'h0001_0000);
        cyc(1, 0, 0, C_CS, 32'h0000_00AA);
        check("csize", {22'd0, csize}, 32'h0AA);
        cyc(0, 1, 0, C_CS, 0);
        check("csize_rd", data_out, 32'h0AA);
        cyc(0, 0, 1, 0, 0);
        check("start_pulse", {31'd0, core_start}, 1);
        cyc(0, 0, 0, 0, 0);
        check("start_pulse_end", {31'd0, core_start}, 0);
        cyc(0, 1, 0, C_ST, 0);
        check("status_busy", data_out, 32'h0001_0100);
        cyc(0, 0, 1, 0, 0);
        check("start_in_busy", {31'd0, core_start}, 0);
        cyc(0, 0, 0, 0, 0);
        check("start_in_busy2", {31'd0, core_start}, 0);
        check("int_req_idle", {31'd0, int_req}, 1);

        // Core fills Z, then signals done
        for (int i = 0; i < 15; i++) begin
            z_we = 1'b1; z_addr = 4'(i); z_data = 32'(i * 3);
            @(negedge clk);
        end
        z_we = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("int_req_lag", {31'd0, int_req}, 1);
        @(negedge clk);
        check("int_req_low", {31'd0, int_req}, 0);
        cyc(0, 1, 0, C_ST, 0);
        check("status_done", data_out, 32'h0001_0001);
        cyc(1, 0, 0, C_AZ, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 0, C_MZ, 0);
            check($sformatf("z_rd%0d", i), data_out, 32'(i * 3));
        end
        cyc(0, 1, 0, C_MZ, 0);
        check("z_wrap", data_out, 0);
        // Core write and host read to the same Z word: host sees old value
        cyc(1, 0, 0, C_AZ, 2);
        z_we = 1'b1; z_addr = 4'd2; z_data = 32'h99;
        cyc(0, 1, 0, C_MZ, 0);
        z_we = 1'b0;
        check("z_collide_old", data_out, 32'h6);
        cyc(1, 0, 0, C_AZ, 2);
        cyc(0, 1, 0, C_MZ, 0);
        check("z_collide_new", data_out, 32'h99);

        // W1C clears the flag, int_req rises one cycle later
        cyc(1, 0, 0, C_ST, 32'h0001_0001);
        check("w1c_int_lag", {31'd0, int_req}, 0);
        cyc(0, 0, 0, 0, 0);
        check("w1c_int_high", {31'd0, int_req}, 1);
        cyc(0, 1, 0, C_ST, 0);
        check("w1c_status", data_out, 32'h0001_0000);
        // Done while idle is ignored
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        cyc(0, 1, 0, C_ST, 0);
        check("done_in_idle", data_out, 32'h0001_0000);
        // Done and W1C together: set wins
        cyc(0, 0, 1, 0, 0);
        core_done = 1'b1;
        cyc(1, 0, 0, C_ST, 32'h0001_0001);
        core_done = 1'b0;
        cyc(0, 1, 0, C_ST, 0);
        check("done_vs_w1c", data_out, 32'h0001_0001);
        cyc(0, 0, 0, 0, 0);
        check("int_req_set_wins", {31'd0, int_req}, 0);

        // Reset in the middle of a read burst while busy
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, C_AX, 0);
        cyc(0, 1, 0, C_MX, 0);
        check("burst0", data_out, 32'hDEAD);
        cyc(0, 1, 0, C_MX, 0);
        check("burst1", data_out, 32'h2);
        read = 1'b1; conf_dbus = C_MX;
        #2 rst_a = 1'b1;
        #1;
        check("mid_rst_dout", data_out, 0);
        check("mid_rst_int_req", {31'd0, int_req}, 1);
        @(negedge clk);
        read = 1'b0;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            check($sformatf("no_pulse%0d", i), {31'd0, core_start}, 0);
        end
        check("post_rst_csize", {22'd0, csize}, 0);
        cyc(0, 1, 0, C_ST, 0);
        check("post_rst_status", data_out, 0);
        cyc(0, 1, 0, C_MX, 0);
        check("post_rst_ptr", data_out, 32'hDEAD);

        // Enable low: host traffic ignored, state held (X pointer is now 1)
        en_s = 1'b0;
        cyc(1, 0, 0, C_AX, 5);
        cyc(1, 0, 0, C_MX, 32'h1234);
        cyc(0, 0, 1, 0, 0);
        check("en_start", {31'd0, core_start}, 0);
        x_addr = 4'd1;
        #1 check("en_hold_x", x_data, 32'h2);
        en_s = 1'b1;
        cyc(1, 0, 0, C_MX, 32'h1234);
        #1 check("en_ptr_held", x_data, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
